// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: default width, RV opcodes, load funct3 codes, FSM states.
package wb_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] FENCE     = 7'b0001111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  // The *_32 word ops only exist on RV64.
  function automatic logic opcode_writes_rd(input logic [6:0] opc, input logic rv64);
    case (opc)
      OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR: return 1'b1;
      OP_32, OP_IMM_32:                        return rv64;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load lane select and sign/zero extension; misaligned accesses fall back to the lower-aligned lane.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int OFF_W = 2
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  result
);

  logic [OFF_W-1:0] off_h;
  logic [OFF_W-1:0] off_w;
  logic [XLEN-1:0]  sh_b;
  logic [XLEN-1:0]  sh_h;
  logic [XLEN-1:0]  sh_w;

  // Clearing the low offset bits aligns the lane; on RV32 the word offset collapses to zero.
  assign off_h = off & ~OFF_W'(1);
  assign off_w = off & ~OFF_W'(3);
  assign sh_b  = rdata >> {off, 3'b000};
  assign sh_h  = rdata >> {off_h, 3'b000};
  assign sh_w  = rdata >> {off_w, 3'b000};

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = XLEN'($signed(sh_b[7:0]));
      F3_LBU:  result = XLEN'(sh_b[7:0]);
      F3_LH:   result = XLEN'($signed(sh_h[15:0]));
      F3_LHU:  result = XLEN'(sh_h[15:0]);
      F3_LW:   result = XLEN'($signed(sh_w[31:0]));
      F3_LWU:  result = XLEN'(sh_w[31:0]);
      F3_LD:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: RUN/HALTED FSM, result select and registered register-file write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_instr,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_alu,
  input  logic [XLEN-1:0]       i_mem_rdata,
  input  logic                  i_halt,
  input  logic                  i_flush,
  output logic                  o_reg_wr_en,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic                  o_retire,
  output logic [CNT_W-1:0]      o_retire_cnt
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  wb_state_e             state;
  wb_state_e             state_nxt;
  logic                  accept;
  logic                  retire_nxt;
  logic                  wr_en_nxt;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       result;

  // Handshake: a transfer happens on a cycle where i_valid and o_ready are both high;
  // MEM must hold its instruction stable while o_ready is low.
  assign o_ready    = (state == RUN) && !i_halt;
  assign accept     = i_valid && o_ready;
  assign opcode     = i_instr[6:0];
  assign rd         = REG_ADDR_W'(i_instr[11:7]);
  assign pc_plus4   = i_pc + XLEN'(4);
  assign retire_nxt = accept && !i_flush;
  assign wr_en_nxt  = retire_nxt && (rd != '0) && opcode_writes_rd(opcode, XLEN == 64);

  wb_load_ext #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_ext (
    .funct3 (i_instr[14:12]),
    .off    (i_alu[OFF_W-1:0]),
    .rdata  (i_mem_rdata),
    .result (load_data)
  );

  always_comb begin
    result = i_alu;
    case (opcode)
      JAL, JALR: result = pc_plus4;
      LOAD:      result = load_data;
      default:   result = i_alu;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (i_halt)  state_nxt = HALTED;
      HALTED:  if (!i_halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= RUN;
      o_reg_wr_en <= 1'b0;
      o_retire    <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
    end else begin
      state       <= state_nxt;
      o_reg_wr_en <= wr_en_nxt;
      o_retire    <= retire_nxt;
      if (retire_nxt) begin
        o_rd_addr <= rd;
        o_rd_data <= result;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) retire_cnt <= '0;
    else if (o_retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  assign o_retire_cnt = retire_cnt;
`else
  assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (RV32 build); counter checks follow WB_RETIRE_CNT_EN.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
`ifdef WB_RETIRE_CNT_EN
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] EXP_CNT_17 = 4'd1;
`else
  localparam int CNT_W = 64;
  localparam logic [CNT_W-1:0] EXP_CNT_17 = '0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [31:0]     i_instr = '0;
  logic [XLEN-1:0] i_pc = '0;
  logic [XLEN-1:0] i_alu = '0;
  logic [XLEN-1:0] i_mem_rdata = '0;
  logic            i_halt = 1'b0;
  logic            i_flush = 1'b0;
  logic            o_reg_wr_en;
  logic [RAW-1:0]  o_rd_addr;
  logic [XLEN-1:0] o_rd_data;
  logic            o_retire;
  logic [CNT_W-1:0] o_retire_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .i_alu        (i_alu),
    .i_mem_rdata  (i_mem_rdata),
    .i_halt       (i_halt),
    .i_flush      (i_flush),
    .o_reg_wr_en  (o_reg_wr_en),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_retire     (o_retire),
    .o_retire_cnt (o_retire_cnt)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3);
    return {17'b0, f3, rd, opc};
  endfunction

  // Drives one valid instruction for one edge, then samples the registered result.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] rdata, input logic flush);
    i_valid = 1'b1; i_instr = instr; i_pc = pc; i_alu = alu; i_mem_rdata = rdata; i_flush = flush;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic idle_cycle();
    i_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic chk_wb(input string tag, input logic wr, input logic [4:0] addr,
                        input logic [31:0] data, input logic ret);
    chk({tag, ".wr_en"}, 64'(o_reg_wr_en), 64'(wr));
    chk({tag, ".addr"},  64'(o_rd_addr),   64'(addr));
    chk({tag, ".data"},  64'(o_rd_data),   64'(data));
    chk({tag, ".retire"}, 64'(o_retire),   64'(ret));
  endtask

  initial begin
    #12;
    chk("rst_wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("rst_addr", 64'(o_rd_addr), 64'd0);
    chk("rst_data", 64'(o_rd_data), 64'd0);
    chk("rst_retire", 64'(o_retire), 64'd0);
    chk("rst_cnt", 64'(o_retire_cnt), 64'd0);
    @(negedge i_clk); i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_run", 64'(o_ready), 64'd1);

    send(mk(OP, 5'd5, 3'b000), 32'h0, 32'h1234, 32'h0, 1'b0);
    chk_wb("add_x5", 1'b1, 5'd5, 32'h0000_1234, 1'b1);

    send(mk(LOAD, 5'd6, F3_LB), 32'h0, 32'h2, 32'h0080_0000, 1'b0);
    chk_wb("lb", 1'b1, 5'd6, 32'hFFFF_FF80, 1'b1);
    send(mk(LOAD, 5'd6, F3_LBU), 32'h0, 32'h2, 32'h0080_0000, 1'b0);
    chk_wb("lbu", 1'b1, 5'd6, 32'h0000_0080, 1'b1);
    send(mk(LOAD, 5'd7, F3_LH), 32'h0, 32'h2, 32'h8001_0000, 1'b0);
    chk_wb("lh", 1'b1, 5'd7, 32'hFFFF_8001, 1'b1);
    send(mk(LOAD, 5'd7, F3_LH), 32'h0, 32'h3, 32'h8001_7F00, 1'b0);
    chk_wb("lh_misal", 1'b1, 5'd7, 32'hFFFF_8001, 1'b1);
    send(mk(LOAD, 5'd8, F3_LHU), 32'h0, 32'h0, 32'h1234_ABCD, 1'b0);
    chk_wb("lhu", 1'b1, 5'd8, 32'h0000_ABCD, 1'b1);
    send(mk(LOAD, 5'd9, F3_LW), 32'h0, 32'h1, 32'h8765_4321, 1'b0);
    chk_wb("lw_misal", 1'b1, 5'd9, 32'h8765_4321, 1'b1);

    send(mk(STORE, 5'd3, 3'b010), 32'h0, 32'h40, 32'h0, 1'b0);
    chk("sw.wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("sw.retire", 64'(o_retire), 64'd1);
    send(mk(OP_IMM, 5'd0, 3'b000), 32'h0, 32'h55, 32'h0, 1'b0);
    chk("addi_x0.wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("addi_x0.retire", 64'(o_retire), 64'd1);
    send(mk(BRANCH, 5'd4, 3'b000), 32'h0, 32'h0, 32'h0, 1'b0);
    chk("branch.wr_en", 64'(o_reg_wr_en), 64'd0);
    send(mk(OP_32, 5'd4, 3'b000), 32'h0, 32'h9, 32'h0, 1'b0);
    chk("op32_rv32.wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("op32_rv32.retire", 64'(o_retire), 64'd1);

    send(mk(LUI, 5'd3, 3'b000), 32'h0, 32'hABCD_E000, 32'h0, 1'b0);
    chk_wb("lui", 1'b1, 5'd3, 32'hABCD_E000, 1'b1);
    send(mk(JAL, 5'd1, 3'b000), 32'h100, 32'h999, 32'h0, 1'b0);
    chk_wb("jal", 1'b1, 5'd1, 32'h0000_0104, 1'b1);
    send(mk(JALR, 5'd2, 3'b000), 32'h200, 32'h0, 32'h0, 1'b1);
    chk_wb("jalr_flush", 1'b0, 5'd1, 32'h0000_0104, 1'b0);
    send(mk(JALR, 5'd2, 3'b000), 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    chk_wb("jalr_wrap", 1'b1, 5'd2, 32'h0000_0000, 1'b1);
    idle_cycle();
    chk_wb("idle_hold", 1'b0, 5'd2, 32'h0000_0000, 1'b0);

    i_valid = 1'b1; i_instr = mk(OP, 5'd10, 3'b000); i_alu = 32'hCAFE; i_halt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("halt.ready", 64'(o_ready), 64'd0);
      @(posedge i_clk); #1;
      chk("halt.wr_en", 64'(o_reg_wr_en), 64'd0);
      chk("halt.retire", 64'(o_retire), 64'd0);
    end
    i_halt = 1'b0; #1;
    chk("unhalt.ready_same", 64'(o_ready), 64'd0);
    @(posedge i_clk); #1;
    chk("unhalt.wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("unhalt.ready_next", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk_wb("after_halt", 1'b1, 5'd10, 32'h0000_CAFE, 1'b1);

    i_valid = 1'b1; i_instr = mk(OP, 5'd11, 3'b000); i_alu = 32'h77;
    @(negedge i_clk); #2;
    i_rst = 1'b0; #1;
    chk_wb("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rst_mid.cnt", 64'(o_retire_cnt), 64'd0);
    @(negedge i_clk); i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst.wr_en", 64'(o_reg_wr_en), 64'd0);
    chk("post_rst.retire", 64'(o_retire), 64'd0);

    for (int k = 0; k < 17; k++) send(mk(OP, 5'd12, 3'b000), 32'h0, 32'(k), 32'h0, 1'b0);
    chk_wb("burst_last", 1'b1, 5'd12, 32'd16, 1'b1);
    idle_cycle();
    chk("cnt_17", 64'(o_retire_cnt), 64'(EXP_CNT_17));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
